// File: rtl/bus_arbiter_pkg.sv
// ============================================================================
// Module      : bus_arbiter_pkg
// Description : Shared state and grant encodings for the two-master arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] c_grant_none = 2'b00;
    localparam logic [1:0] c_grant_m0   = 2'b01;
    localparam logic [1:0] c_grant_m1   = 2'b10;

    function automatic logic [1:0] grant_of(input arb_state_t s);
        case (s)
            OWN0:    grant_of = c_grant_m0;
            OWN1:    grant_of = c_grant_m1;
            default: grant_of = c_grant_none;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_timeout_counter.sv
// ============================================================================
// Module      : bus_timeout_counter
// Description : Saturating wait counter; flags expiry when count hits limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_timeout_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero limit disables expiry entirely.
    assign expired_o = (limit_i != '0) && (cnt_q == limit_i);

endmodule

`default_nettype wire

// File: rtl/bus_arbiter_2m.sv
// ============================================================================
// Module      : bus_arbiter_2m
// Description : Round-robin two-master single-slave bus arbiter with watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter_2m
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_data_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_ack_i,
    output logic [1:0]            grant_o
);

    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    arb_state_t state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [1:0] grant_q, grant_d;
    logic       expired, timeout, req0, req1;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;
    // An ack in the expiry cycle completes the transfer normally.
    assign timeout = expired & ~s_ack_i;

    bus_timeout_counter #(
        .WIDTH(CW)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_q == IDLE),
        .en_i     ((state_q != IDLE) & ~s_ack_i),
        .limit_i  (CW'(TIMEOUT_CYCLES)),
        .expired_o(expired)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d      = last_grant_q ? OWN0 : OWN1;
                    last_grant_d = ~last_grant_q;
                end else if (req0) begin
                    state_d      = OWN0;
                    last_grant_d = 1'b0;
                end else if (req1) begin
                    state_d      = OWN1;
                    last_grant_d = 1'b1;
                end
            end
            OWN0:    if (s_ack_i || !m0_cyc_i || timeout) state_d = IDLE;
            OWN1:    if (s_ack_i || !m1_cyc_i || timeout) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        grant_d = grant_of(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= c_grant_none;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
        end
    end

    assign grant_o = grant_q;

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_data_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            OWN0: begin
                s_cyc_o  = m0_cyc_i & ~timeout;
                s_stb_o  = m0_stb_i & ~timeout;
                s_we_o   = m0_we_i;
                s_addr_o = m0_addr_i;
                s_data_o = m0_data_i;
                m0_ack_o = s_ack_i;
                m0_err_o = timeout;
            end
            OWN1: begin
                s_cyc_o  = m1_cyc_i & ~timeout;
                s_stb_o  = m1_stb_i & ~timeout;
                s_we_o   = m1_we_i;
                s_addr_o = m1_addr_i;
                s_data_o = m1_data_i;
                m1_ack_o = s_ack_i;
                m1_err_o = timeout;
            end
            default: ;
        endcase
    end

    // Read data is held at zero while idle so reset leaves it cleared.
    assign m0_data_o = (state_q != IDLE) ? s_data_i : '0;
    assign m1_data_o = (state_q != IDLE) ? s_data_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter_2m.sv
// ============================================================================
// Module      : tb_bus_arbiter_2m
// Description : Randomized scoreboard bench for bus_arbiter_2m.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter_2m;

    localparam int T      = 4;
    localparam int CYCLES = 3000;

    typedef struct {
        logic [1:0]  grant;
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } cyc_t;

    typedef struct {
        logic [3:0]  flags;   // {m1_err, m0_err, m1_ack, m0_ack}
        logic [31:0] data;
    } tx_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_cyc[2];
    logic        m_stb[2];
    logic        m_we[2];
    logic [31:0] m_addr[2];
    logic [31:0] m_wdata[2];
    logic [31:0] s_data_i = '0;
    logic        s_ack_i  = 1'b0;

    logic [31:0] m0_data_o, m1_data_o, s_addr_o, s_data_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [1:0]  grant_o;

    bus_arbiter_2m #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_cyc_i (m_cyc[0]),
        .m0_stb_i (m_stb[0]),
        .m0_we_i  (m_we[0]),
        .m0_addr_i(m_addr[0]),
        .m0_data_i(m_wdata[0]),
        .m0_data_o(m0_data_o),
        .m0_ack_o (m0_ack_o),
        .m0_err_o (m0_err_o),
        .m1_cyc_i (m_cyc[1]),
        .m1_stb_i (m_stb[1]),
        .m1_we_i  (m_we[1]),
        .m1_addr_i(m_addr[1]),
        .m1_data_i(m_wdata[1]),
        .m1_data_o(m1_data_o),
        .m1_ack_o (m1_ack_o),
        .m1_err_o (m1_err_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_we_o   (s_we_o),
        .s_addr_o (s_addr_o),
        .s_data_o (s_data_o),
        .s_data_i (s_data_i),
        .s_ack_i  (s_ack_i),
        .grant_o  (grant_o)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    bit   run   = 1'b1;
    cyc_t cq[$];
    tx_t  tq[$];

    // Reference model: who owns the bus, who was granted last, cycles waited.
    int owner = -1;
    int last  = 1;
    int waited = 0;
    int dly   = 0;
    bit pend[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, 64'({s_cyc_o, s_stb_o, s_we_o, grant_o,
                                  m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 64'd0);
        check({tag, "_saddr"}, 64'(s_addr_o), 64'd0);
        check({tag, "_swdata"}, 64'(s_data_o), 64'd0);
        check({tag, "_m0data"}, 64'(m0_data_o), 64'd0);
        check({tag, "_m1data"}, 64'(m1_data_o), 64'd0);
    endtask

    task automatic new_txn(input int m);
        pend[m]    = 1'b1;
        m_we[m]    = 1'($urandom_range(1));
        m_addr[m]  = $urandom;
        m_wdata[m] = $urandom;
    endtask

    task automatic step(input bit tie);
        cyc_t c;
        tx_t  t;
        bit   to;
        int   n;
        for (int m = 0; m < 2; m++) begin
            if (tie) new_txn(m);
            else if (pend[m]) begin
                if ($urandom_range(15) == 0) pend[m] = 1'b0;
            end else if ($urandom_range(1) == 1) new_txn(m);
            if (pend[m]) begin
                m_cyc[m] = 1'b1;
                m_stb[m] = 1'b1;
            end else begin
                m_stb[m] = 1'b0;
                m_cyc[m] = ($urandom_range(3) == 0);
            end
        end
        s_data_i = $urandom;
        s_ack_i  = (owner >= 0) ? (waited == dly) : ($urandom_range(3) == 0);

        c.grant = 2'b00; c.cyc = 1'b0; c.stb = 1'b0; c.we = 1'b0;
        c.addr = '0; c.data = '0;
        if (owner >= 0) begin
            n       = owner;
            to      = (waited == T) && !s_ack_i;
            c.grant = (n == 0) ? 2'b01 : 2'b10;
            c.cyc   = m_cyc[n] && !to;
            c.stb   = m_stb[n] && !to;
            c.we    = m_we[n];
            c.addr  = m_addr[n];
            c.data  = m_wdata[n];
            if (s_ack_i) begin
                t.flags = (n == 0) ? 4'b0001 : 4'b0010;
                t.data  = s_data_i;
                tq.push_back(t);
                pend[n] = 1'b0;
            end else if (to) begin
                t.flags = (n == 0) ? 4'b0100 : 4'b1000;
                t.data  = '0;
                tq.push_back(t);
                pend[n] = 1'b0;
            end
            if (s_ack_i || to || !m_cyc[n]) owner = -1;
            else waited++;
        end else begin
            if ((m_cyc[0] && m_stb[0]) && (m_cyc[1] && m_stb[1])) n = (last == 1) ? 0 : 1;
            else if (m_cyc[0] && m_stb[0]) n = 0;
            else if (m_cyc[1] && m_stb[1]) n = 1;
            else n = -1;
            if (n >= 0) begin
                owner  = n;
                last   = n;
                waited = 0;
                dly    = $urandom_range(6);
            end
        end
        cq.push_back(c);
    endtask

    // Monitor: compares DUT outputs against the queued expectations.
    initial begin
        cyc_t       c;
        tx_t        t;
        logic [3:0] flags;
        forever begin
            @(negedge clk);
            #4;
            if (!rst && run) begin
                if (cq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL cycq_empty: got 0 entries expected 1 at %0t", $time);
                end else begin
                    c = cq.pop_front();
                    check("grant", 64'(grant_o), 64'(c.grant));
                    check("s_ctl", 64'({s_cyc_o, s_stb_o, s_we_o}), 64'({c.cyc, c.stb, c.we}));
                    check("s_addr", 64'(s_addr_o), 64'(c.addr));
                    check("s_wdata", 64'(s_data_o), 64'(c.data));
                end
                flags = {m1_err_o, m0_err_o, m1_ack_o, m0_ack_o};
                if (flags != 4'b0000 || tq.size() > 0) begin
                    if (tq.size() == 0) begin
                        check("resp_unexpected", 64'(flags), 64'd0);
                    end else begin
                        t = tq.pop_front();
                        check("resp_flags", 64'(flags), 64'(t.flags));
                        if (t.flags[0]) check("m0_rdata", 64'(m0_data_o), 64'(t.data));
                        if (t.flags[1]) check("m1_rdata", 64'(m1_data_o), 64'(t.data));
                    end
                end
            end
        end
    end

    // Stimulus and reference model.
    initial begin
        bit did_rst = 1'b0;
        for (int m = 0; m < 2; m++) begin
            m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
            m_addr[m] = '0; m_wdata[m] = '0; pend[m] = 1'b0;
        end
        s_data_i = 32'hA5A5_5A5A;
        @(negedge clk);
        #1;
        check_quiet("reset");
        for (int i = 0; i < CYCLES; i++) begin
            @(negedge clk);
            rst = 1'b0;
            if (i >= CYCLES / 2 && !did_rst && owner >= 0) begin
                did_rst  = 1'b1;
                s_ack_i  = 1'b1;
                s_data_i = 32'hFFFF_0001;
                rst      = 1'b1;
                #1;
                check_quiet("midrst");
                @(negedge clk);
                rst    = 1'b0;
                owner  = -1;
                last   = 1;
                waited = 0;
                step(1'b1);
            end else begin
                step(1'b0);
            end
        end
        @(negedge clk);
        run = 1'b0;
        total++;
        if (!did_rst) begin
            bad++;
            $display("FAIL midrst_reached: got 0 expected 1");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
